mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096, halfwords in the attached memory.
REQ-002 SHALL have localparam ADDR_WIDTH, $clog2(MEM_DEPTH), halfword address width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports req_valid[1:0]  input  2  request strobe per requester (0 = instruction fetch, 1 = data).
REQ-006 SHALL have ports req_we[1:0]  input  2  per-requester write (1) / read (0).
REQ-007 SHALL have ports req_addr0, req_addr1  input  ADDR_WIDTH each  per-requester halfword address.
REQ-008 SHALL have ports req_wdata0, req_wdata1  input  16 each  per-requester write data.
REQ-009 SHALL have port req_ready[1:0]  output  2  grant: request accepted this cycle.
REQ-010 SHALL have port rsp_valid[1:0]  output  2  read data valid for requester i.
REQ-011 SHALL have port rsp_rdata  output  16  read data shared by both requesters.
REQ-012 SHALL have ports mem_en, mem_rd_en, mem_wr_en  output  1 each  memory strobes.
REQ-013 SHALL have ports mem_addr  output  ADDR_WIDTH, mem_din  output  16, mem_dout  input  16  memory address/data.

Function
REQ-014 SHALL accept at most one request per cycle; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-015 SHALL compute req_ready combinationally from req_valid and the priority pointer; req_ready[i] never high without req_valid[i].
REQ-016 SHALL arbitrate round-robin: single request is granted immediately; on conflict the requester not granted most recently wins.
REQ-017 SHALL update the last-grant pointer only on an accepted transfer; idle cycles leave it unchanged.
REQ-018 SHALL drive mem_en=1, mem_addr/mem_din from the granted requester, mem_wr_en=req_we, mem_rd_en=~req_we in the grant cycle; all strobes 0 when no grant.
REQ-019 SHALL assert rsp_valid[i] for exactly one cycle, the cycle after an accepted read from requester i (1-cycle latency); writes produce no response.
REQ-020 SHALL drive rsp_rdata = mem_dout whenever any rsp_valid is high; value is don't-care otherwise.
REQ-021 SHALL sustain back-to-back accesses every cycle, including alternating requesters and read-after-write to the same address (read returns new data).
REQ-022 SHALL bound wait: with both requesters continuously valid, each is granted at least every second cycle.
REQ-023 SHALL require requesters to hold req_valid/we/addr/wdata stable until granted; behaviour on early withdrawal is only that the request is not performed.
REQ-024 SHALL keep the response pipeline (response-pending flag, port tag) as registers; no other state besides the last-grant pointer.

Reset
REQ-025 SHALL on rst force last-grant pointer to 1 (requester 0 wins the first conflict), response-pending to 0.
REQ-026 SHALL hold req_ready=0, all mem strobes 0 and rsp_valid=0 during any cycle rst is high.
REQ-027 SHALL suppress rsp_valid in the cycle after reset deasserts even if a read was granted in the cycle before rst asserted.

Structure
REQ-028 SHALL place requester index constants (PORT_IF=0, PORT_DATA=1) and a response-tag typedef in package mem_arb_pkg.
REQ-029 SHALL implement grant selection in sub-module rr_arb2 (two-way round-robin, inputs valid[1:0] and pointer, output one-hot grant).
REQ-030 SHALL connect one-to-one to the team's single-port 16-bit memory (en, rd_en, wr_en, addr, din, dout).

Verification
REQ-031 SHALL test: only port 0 reads addr 0x010 after writing 0x1234 -> rsp_valid[0] one cycle after grant, rsp_rdata=0x1234.
REQ-032 SHALL test: both valid for 6 cycles after reset, port 0 addr 0x001, port 1 addr 0x002 -> grants alternate 0,1,0,1,0,1.
REQ-033 SHALL test: port 1 writes 0xBEEF to 0x0FF, port 0 reads 0x0FF next cycle -> rsp_rdata=0xBEEF, rsp_valid=2'b01.
REQ-034 SHALL test: read granted, rst pulsed next cycle -> rsp_valid stays 0, pointer reset, first conflict then grants port 0.
REQ-035 SHALL test: idle gap of 3 cycles between conflicting bursts -> pointer unchanged across idle, no spurious mem_en.
REQ-036 SHALL test: write to address MEM_DEPTH-1 (0xFFF) with 0xA5A5, then read -> 0xA5A5, no aliasing to 0x000.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: requester indices,
// bus widths and the response-tag register layout.
package mem_arb_pkg;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int NUM_PORTS  = 2;
  localparam int DATA_WIDTH = 16;

  // One read may be in flight; the tag remembers which requester gets the data.
  typedef struct packed {
    logic pending;
    logic port;
  } rsp_tag_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; purely combinational.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  // A lone request wins outright; on a tie the requester that was not
  // granted most recently takes the slot.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == PORT_DATA) ? port_onehot(PORT_IF) : port_onehot(PORT_DATA);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch and data
// requesters, with round-robin arbitration and a one-cycle read response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MEM_DEPTH  = 4096,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  req_valid,
  input  logic [NUM_PORTS-1:0]  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [NUM_PORTS-1:0]  req_ready,
  output logic [NUM_PORTS-1:0]  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic                 last_grant;
  rsp_tag_t             tag_q;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [NUM_PORTS-1:0] grant;
  logic                 granted;
  logic                 sel;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  // Reset blocks every grant so nothing reaches memory while rst is high.
  always_comb begin
    grant   = rst ? '0 : arb_grant;
    granted = |grant;
    sel     = grant[PORT_DATA];
  end

  always_comb begin
    req_ready = grant;
    mem_en    = granted;
    mem_wr_en = granted & req_we[sel];
    mem_rd_en = granted & ~req_we[sel];
    mem_addr  = '0;
    mem_din   = '0;
    if (granted) begin
      mem_addr = (sel == PORT_DATA) ? req_addr1  : req_addr0;
      mem_din  = (sel == PORT_DATA) ? req_wdata1 : req_wdata0;
    end
  end

  // The memory returns read data one cycle after the strobe, so the response
  // is just the registered tag; the rst mask covers a read granted just
  // before reset asserted.
  always_comb begin
    rsp_valid = '0;
    if (tag_q.pending && !rst) begin
      rsp_valid = port_onehot(tag_q.port);
    end
    rsp_rdata = mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_DATA;
      tag_q      <= '0;
    end else begin
      if (granted) begin
        last_grant <= sel;
      end
      tag_q.pending <= granted & ~req_we[sel];
      tag_q.port    <= sel;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table followed by
// randomized traffic compared against a request-level reference model.
module tb_mem_arbiter;

  localparam int MEM_DEPTH = 4096;
  localparam int AW        = 12;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [15:0]   req_wdata0;
  logic [15:0]   req_wdata1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [15:0]   rsp_rdata;
  logic          mem_en;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;

  typedef struct {
    bit            rst;
    logic [1:0]    valid;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [15:0]   d0;
    logic [15:0]   d1;
    bit            chk;
    logic [1:0]    exp_ready;
    logic [1:0]    exp_rsp;
    logic [15:0]   exp_rdata;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_model [MEM_DEPTH];
  logic [15:0] ref_mem   [MEM_DEPTH];

  // Reference model state: who was granted last and the one outstanding read.
  int          m_last;
  bit          m_rsp_valid;
  int          m_rsp_port;
  logic [15:0] m_rsp_data;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_en     (mem_en),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached single-port memory with a one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_en && mem_wr_en) mem_model[mem_addr] <= mem_din;
    if (mem_en && mem_rd_en) mem_dout <= mem_model[mem_addr];
  end

  function automatic vec_t mk(bit r, logic [1:0] va, logic [1:0] we,
                              logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] er, logic [1:0] ersp, logic [15:0] ed);
    vec_t v;
    v.rst = r; v.valid = va; v.we = we; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.chk = 1'b1;
    v.exp_ready = er; v.exp_rsp = ersp; v.exp_rdata = ed;
    return v;
  endfunction

  // Round-robin rule: a single requester wins, on a tie the one not served last.
  function automatic logic [1:0] ref_grant(logic [1:0] v, int last);
    if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx, output logic [1:0] g_out);
    logic [1:0] g;
    logic [1:0] exp_rsp;
    int         p;
    rst        = v.rst;
    req_valid  = v.valid;
    req_we     = v.we;
    req_addr0  = v.a0;
    req_addr1  = v.a1;
    req_wdata0 = v.d0;
    req_wdata1 = v.d1;
    #3;
    g       = v.rst ? 2'b00 : ref_grant(v.valid, m_last);
    p       = g[1] ? 1 : 0;
    exp_rsp = (!v.rst && m_rsp_valid) ? ((m_rsp_port == 1) ? 2'b10 : 2'b01) : 2'b00;

    checkOutput($sformatf("c%0d ready", idx), 32'(req_ready), 32'(g));
    checkOutput($sformatf("c%0d mem_en", idx), 32'(mem_en), 32'(|g));
    checkOutput($sformatf("c%0d mem_wr_en", idx), 32'(mem_wr_en), 32'((|g) && v.we[p]));
    checkOutput($sformatf("c%0d mem_rd_en", idx), 32'(mem_rd_en), 32'((|g) && !v.we[p]));
    if (|g) begin
      checkOutput($sformatf("c%0d mem_addr", idx), 32'(mem_addr), 32'((p == 1) ? v.a1 : v.a0));
      checkOutput($sformatf("c%0d mem_din", idx), 32'(mem_din), 32'((p == 1) ? v.d1 : v.d0));
    end
    checkOutput($sformatf("c%0d rsp_valid", idx), 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != 2'b00) begin
      checkOutput($sformatf("c%0d rsp_rdata", idx), 32'(rsp_rdata), 32'(m_rsp_data));
    end

    if (v.chk) begin
      checkOutput($sformatf("v%0d tbl_ready", idx), 32'(req_ready), 32'(v.exp_ready));
      checkOutput($sformatf("v%0d tbl_rsp", idx), 32'(rsp_valid), 32'(v.exp_rsp));
      if (v.exp_rsp != 2'b00) begin
        checkOutput($sformatf("v%0d tbl_rdata", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
      end
    end

    if (v.rst) begin
      m_last      = 1;
      m_rsp_valid = 0;
    end else if (|g) begin
      m_last      = p;
      m_rsp_valid = !v.we[p];
      m_rsp_port  = p;
      if (v.we[p]) ref_mem[(p == 1) ? v.a1 : v.a0] = (p == 1) ? v.d1 : v.d0;
      else         m_rsp_data = ref_mem[(p == 1) ? v.a1 : v.a0];
    end else begin
      m_rsp_valid = 0;
    end
    g_out = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]    g;
    vec_t          v;
    bit            pend [2];
    logic          we_r [2];
    logic [AW-1:0] a_r  [2];
    logic [15:0]   d_r  [2];

    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem_model[i] = 16'h0000;
      ref_mem[i]   = 16'h0000;
    end
    mem_dout = 16'h0000;
    m_last = 1; m_rsp_valid = 0; m_rsp_port = 0; m_rsp_data = 16'h0000;
    rst = 1'b1; req_valid = 2'b00; req_we = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with both requesters asking.
    vecs.push_back(mk(1, 2'b11, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    // Port 0 write then read of 0x010.
    vecs.push_back(mk(0, 2'b01, 2'b01, 12'h010, 12'h000, 16'h1234, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 12'h010, 12'h000, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b01, 16'h1234));
    // Six-cycle conflict straight after reset alternates 0,1,0,1,0,1.
    vecs.push_back(mk(1, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(0, 2'b11, 2'b00, 12'h001, 12'h002, 16'h0, 16'h0,
                        (k % 2 == 1) ? 2'b10 : 2'b01,
                        (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10), 16'h0));
    end
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b10, 16'h0));
    // Port 1 writes 0xBEEF, port 0 reads it back the next cycle.
    vecs.push_back(mk(0, 2'b10, 2'b10, 12'h000, 12'h0FF, 16'h0, 16'hBEEF, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 12'h0FF, 12'h000, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b01, 16'hBEEF));
    // Read granted, then reset: response dropped and the pointer returns to 1.
    vecs.push_back(mk(0, 2'b01, 2'b00, 12'h0FF, 12'h000, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 12'h001, 12'h002, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b01, 16'h0));
    // Conflict, three idle cycles, conflict: pointer survives the gap.
    vecs.push_back(mk(0, 2'b11, 2'b00, 12'h001, 12'h002, 16'h0, 16'h0, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 12'h001, 12'h002, 16'h0, 16'h0, 2'b01, 2'b10, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b01, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 12'h001, 12'h002, 16'h0, 16'h0, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b10, 16'h0));
    // Top address holds its data and does not alias onto 0x000.
    vecs.push_back(mk(0, 2'b10, 2'b10, 12'h000, 12'hFFF, 16'h0, 16'hA5A5, 2'b10, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 12'hFFF, 12'h000, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b10, 2'b01, 16'hA5A5));
    vecs.push_back(mk(0, 2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 2'b00, 2'b10, 16'h0000));

    foreach (vecs[i]) applyStimulus(vecs[i], i, g);

    // Random traffic; a request is held unchanged until the model grants it.
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; we_r[p] = 0; a_r[p] = '0; d_r[p] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 9) < 6)) begin
          pend[p] = 1;
          we_r[p] = ($urandom_range(0, 2) == 0);
          case ($urandom_range(0, 5))
            0:       a_r[p] = 12'hFFF;
            1:       a_r[p] = 12'h000;
            default: a_r[p] = AW'($urandom_range(0, 15));
          endcase
          d_r[p] = 16'($urandom);
        end
      end
      v.rst   = ($urandom_range(0, 49) == 0);
      v.valid = {pend[1], pend[0]};
      v.we    = {we_r[1], we_r[0]};
      v.a0 = a_r[0]; v.a1 = a_r[1]; v.d0 = d_r[0]; v.d1 = d_r[1];
      v.chk = 1'b0; v.exp_ready = 2'b00; v.exp_rsp = 2'b00; v.exp_rdata = 16'h0;
      applyStimulus(v, 1000 + c, g);
      if (g[0]) pend[0] = 0;
      if (g[1]) pend[1] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
